reg_wb_ctrl: RTL

Write-back initiator for the 8x32 register file; it drives that file's write port (we[1:0], r_write_enc, wdata).
- Accepts half-word-masked write requests from the execute stage over a valid/ready handshake.
- Queues requests in a small in-order FIFO and drains one entry per cycle onto the register-file write port.
- Exposes per-register pending flags so decode can detect read-after-write hazards against queued writes.

---
 rtl/reg_wb_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/reg_wb_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared constants and the queue entry type for the register-file write-back path.
package reg_wb_pkg;
    localparam int WB_ENC_W  = 3;
    localparam int WB_DATA_W = 32;
    localparam logic [2:0] R0_ENC = 3'b000;
    localparam logic [2:0] R1_ENC = 3'b001;
    localparam logic [2:0] R2_ENC = 3'b010;
    localparam logic [2:0] R3_ENC = 3'b011;
    localparam logic [2:0] R4_ENC = 3'b100;
    localparam logic [2:0] R5_ENC = 3'b101;
    localparam logic [2:0] R6_ENC = 3'b110;
    localparam logic [2:0] R7_ENC = 3'b111;
    localparam logic [1:0] MASK_LO  = 2'b01;
    localparam logic [1:0] MASK_HI  = 2'b10;
    localparam logic [1:0] MASK_ALL = 2'b11;
    typedef struct packed {
        logic [WB_ENC_W-1:0]  enc;
        logic [1:0]           mask;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;
    function automatic logic [WB_DATA_W-1:0] merge_data(input logic [WB_DATA_W-1:0] old_d,
                                                        input logic [WB_DATA_W-1:0] new_d,
                                                        input logic [1:0] m);
        return {m[1] ? new_d[31:16] : old_d[31:16], m[0] ? new_d[15:0] : old_d[15:0]};
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order write-back queue with occupancy, per-slot valid flags and a tail-modify port.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    input  logic                        mod_en,
    input  logic [1:0]                  mod_mask,
    input  logic [WB_DATA_W-1:0]        mod_data,
    output wb_entry_t                   head,
    output wb_entry_t                   tail,
    output wb_entry_t [DEPTH-1:0]       entries,
    output logic [DEPTH-1:0]            valid,
    output logic [AW:0]                 count,
    output logic                        empty,
    output logic                        full
);
    wb_entry_t [DEPTH-1:0] mem;
    logic [AW-1:0] wr_ptr, rd_ptr, tail_idx;

    assign tail_idx = wr_ptr - AW'(1);
    assign head     = mem[rd_ptr];
    assign tail     = mem[tail_idx];
    assign entries  = mem;
    assign empty    = count == '0;
    assign full     = count == (AW+1)'(DEPTH);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (mod_en) begin
                mem[tail_idx].mask <= mem[tail_idx].mask | mod_mask;
                mem[tail_idx].data <= merge_data(mem[tail_idx].data, mod_data, mod_mask);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_v
        logic [AW-1:0] off;
        assign off      = AW'(i) - rd_ptr;
        assign valid[i] = {1'b0, off} < count;
    end
endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: queued half-word-masked write-back initiator for the 8x32 register file with hazard flags.
// Optional tail merging of same-register pushes is enabled by defining WB_MERGE_EN.
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ENC_W  = 3,
    parameter int DATA_W = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ENC_W-1:0]  req_enc,
    input  logic [1:0]        req_mask,
    input  logic [DATA_W-1:0] req_data,
    input  logic              drain_en,
    output logic [1:0]        we,
    output logic [ENC_W-1:0]  r_write_enc,
    output logic [DATA_W-1:0] wdata,
    input  logic [ENC_W-1:0]  q_enc_0,
    input  logic [ENC_W-1:0]  q_enc_1,
    output logic              q_busy_0,
    output logic              q_busy_1,
    output logic [AW:0]       count,
    output logic              empty
);
    wb_entry_t head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0] valid;
    logic full, pop, alloc, merge, can_merge;

    assign pop = drain_en & ~empty;

`ifdef WB_MERGE_EN
    wb_entry_t tail;
    // The tail cannot absorb a merge while it is the entry leaving this cycle.
    assign can_merge = ~empty && tail.enc == req_enc && !(pop && count == (AW+1)'(1));
    assign req_ready = ~full | can_merge;
    assign merge     = req_valid & req_ready & (|req_mask) & can_merge;
`else
    assign can_merge = 1'b0;
    assign req_ready = ~full;
    assign merge     = 1'b0;
`endif
    assign alloc = req_valid & req_ready & (|req_mask) & ~can_merge;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (alloc),
        .push_entry ('{enc: req_enc, mask: req_mask, data: req_data}),
        .pop        (pop),
        .mod_en     (merge),
        .mod_mask   (req_mask),
        .mod_data   (req_data),
        .head       (head),
`ifdef WB_MERGE_EN
        .tail       (tail),
`else
        .tail       (),
`endif
        .entries    (entries),
        .valid      (valid),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we          <= 2'b00;
            r_write_enc <= '0;
            wdata       <= '0;
        end else if (pop) begin
            we          <= head.mask;
            r_write_enc <= head.enc;
            wdata       <= head.data;
        end else begin
            we          <= 2'b00;
        end
    end

    // The output register is excluded: its write lands before decode reads.
    always_comb begin
        q_busy_0 = 1'b0;
        q_busy_1 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            q_busy_0 = q_busy_0 | (valid[k] && |entries[k].mask && entries[k].enc == q_enc_0);
            q_busy_1 = q_busy_1 | (valid[k] && |entries[k].mask && entries[k].enc == q_enc_1);
        end
    end
endmodule
